// File: rtl/ifns_decoder_seq.sv
// Serial decoder for IFNS (Fibonacci numeral system) crosstalk-avoidance codewords.
// One codeword bit is folded into the accumulator per clock, LSB first, with
// running Fibonacci weights. Valid/ready handshakes on both sides.
// Optional forbidden-transition check enabled by defining IFNS_FTF_CHECK_EN.
module ifns_decoder_seq #(
  parameter int unsigned N  = 29,
  parameter int unsigned VW = 21
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [N-1:0]  cw_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [VW-1:0] v_o,
  output logic          err_o
);

  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [VW-1:0]   acc_q, acc_d;
  logic [VW-1:0]   wa_q, wa_d;
  logic [VW-1:0]   wb_q, wb_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [VW-1:0]   v_q, v_d;
  logic            out_valid_q, out_valid_d;

  logic [VW-1:0]   acc_sum;
  logic [VW-1:0]   w_sum;
  logic            last_bit;
  logic            accept;
  logic            running;

  // The only two adders: accumulator and weight recurrence.
  assign acc_sum  = acc_q + (sr_q[0] ? wa_q : '0);
  assign w_sum    = wa_q + wb_q;
  assign last_bit = (idx_q == IdxW'(N - 1));
  assign accept   = (state_q == StIdle) && in_valid_i;
  assign running  = (state_q == StRun);

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    wa_d        = wa_q;
    wb_d        = wb_q;
    idx_d       = idx_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sr_d    = cw_i;
          acc_d   = '0;
          wa_d    = VW'(1);
          wb_d    = VW'(1);
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sum;
        wa_d  = wb_q;
        wb_d  = w_sum;
        sr_d  = sr_q >> 1;
        idx_d = idx_q + IdxW'(1);
        if (last_bit) begin
          idx_d       = '0;
          v_d         = acc_sum;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      acc_q       <= '0;
      wa_q        <= '0;
      wb_q        <= '0;
      idx_q       <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      wa_q        <= wa_d;
      wb_q        <= wb_d;
      idx_q       <= idx_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef IFNS_FTF_CHECK_EN
  logic p1_q, p1_d;     // bit i-1
  logic p2_q, p2_d;     // bit i-2
  logic ferr_q, ferr_d; // sticky forbidden-pattern flag for the word in flight
  logic err_q, err_d;
  logic ftf_hit;

  // 101 and 010 are exactly the triples where both adjacent pairs differ.
  assign ftf_hit = (idx_q >= IdxW'(2)) && (sr_q[0] != p1_q) && (p1_q != p2_q);

  // Track the last two bits and fold violations into the sticky flag.
  always_comb begin
    p1_d   = p1_q;
    p2_d   = p2_q;
    ferr_d = ferr_q;
    err_d  = err_q;
    if (accept) begin
      p1_d   = 1'b0;
      p2_d   = 1'b0;
      ferr_d = 1'b0;
    end else if (running) begin
      p2_d   = p1_q;
      p1_d   = sr_q[0];
      ferr_d = ferr_q | ftf_hit;
      if (last_bit) begin
        err_d = ferr_q | ftf_hit;
      end
    end
  end

  // Check-logic registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p1_q   <= 1'b0;
      p2_q   <= 1'b0;
      ferr_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      ferr_q <= ferr_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign v_o         = v_q;

endmodule

// File: tb/tb_ifns_decoder_seq.sv
// Directed bench for ifns_decoder_seq (N=29). A second instance with VW=20
// runs in lockstep to cover output truncation.
module tb_ifns_decoder_seq;

  localparam int unsigned N = 29;
`ifdef IFNS_FTF_CHECK_EN
  localparam bit Ftf = 1'b1;
`else
  localparam bit Ftf = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  cw;
  logic          out_valid;
  logic          out_ready;
  logic [20:0]   v;
  logic          err;
  logic          in_ready20;
  logic          out_valid20;
  logic [19:0]   v20;
  logic          err20;

  int n_checks = 0;
  int n_fail   = 0;

  ifns_decoder_seq #(.N(N), .VW(21)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .cw_i        (cw),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .v_o         (v),
    .err_o       (err)
  );

  ifns_decoder_seq #(.N(N), .VW(20)) u_dut20 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready20),
    .cw_i        (cw),
    .out_valid_o (out_valid20),
    .out_ready_i (out_ready),
    .v_o         (v20),
    .err_o       (err20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word once the decoder is ready; returns just after the acceptance edge.
  task automatic accept(input string tag, input logic [N-1:0] c);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq({tag, " in_ready timeout"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    cw       = c;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; optionally wiggle in_valid/cw meanwhile.
  task automatic wait_out(input string tag, input bit noise, input logic [N-1:0] noise_cw,
                          output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (noise) begin
        in_valid = i[0];
        cw       = noise_cw;
      end
      tick();
      lat++;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    check_eq({tag, " out_valid seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic run_word(input string tag, input logic [N-1:0] c, input logic [63:0] ev,
                          input logic ee, input bit noise, input logic [N-1:0] noise_cw);
    int lat;
    accept(tag, c);
    wait_out(tag, noise, noise_cw, lat);
    check_eq({tag, " latency"}, 64'(lat), 64'd29);
    check_eq({tag, " v"}, 64'(v), ev);
    check_eq({tag, " err"}, {63'd0, err}, {63'd0, ee});
    check_eq({tag, " in_ready in done"}, {63'd0, in_ready}, 64'd0);
    tick();
    check_eq({tag, " out_valid after handshake"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    cw        = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("reset in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("reset out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("reset v", 64'(v), 64'd0);
    check_eq("reset err", {63'd0, err}, 64'd0);

    // Single words, out_ready held high.
    run_word("cw0", 29'h0, 64'd0, 1'b0, 1'b0, '0);
    run_word("cw1", 29'h1, 64'd1, 1'b0, 1'b0, '0);
    run_word("cw3", 29'h3, 64'd2, 1'b0, 1'b0, '0);
    run_word("cw_ones", 29'h1FFF_FFFF, 64'd1346268, 1'b0, 1'b0, '0);
    check_eq("cw_ones vw20 v", 64'(v20), 64'd297692);
    run_word("cw30", 29'h30, 64'd13, 1'b0, 1'b0, '0);
    run_word("cw_msb", 29'h1000_0000, 64'd514229, 1'b0, 1'b0, '0);
    run_word("cw5", 29'h5, 64'd3, Ftf, 1'b0, '0);
    run_word("cw2", 29'h2, 64'd1, Ftf, 1'b0, '0);

    // Backpressure: result and handshake state must hold while out_ready is low.
    out_ready = 1'b0;
    accept("bp", 29'h30);
    wait_out("bp", 1'b0, '0, lat);
    check_eq("bp latency", 64'(lat), 64'd29);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp v hold", 64'(v), 64'd13);
      check_eq("bp out_valid hold", {63'd0, out_valid}, 64'd1);
      check_eq("bp in_ready low", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cw        = 29'h3;
    tick();
    check_eq("bp handshake out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("bp idle in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp second accepted", {63'd0, in_ready}, 64'd0);
    wait_out("bp2", 1'b0, '0, lat);
    check_eq("bp2 latency", 64'(lat), 64'd29);
    check_eq("bp2 v", 64'(v), 64'd2);
    tick();

    // in_valid wiggling with another codeword during RUN must be ignored.
    run_word("noise", 29'h3, 64'd2, 1'b0, 1'b1, 29'h1FFF_FFFF);

    // Reset in the middle of a word.
    accept("midrst", 29'h1FFF_FFFF);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst v", 64'(v), 64'd0);
    check_eq("midrst in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("midrst released in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("midrst released out_valid", {63'd0, out_valid}, 64'd0);
    run_word("after_rst", 29'h30, 64'd13, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifns_decoder_seq.md
# ifns_decoder_seq

Parametrised, multi-cycle decoder for Fibonacci-numeral-system (IFNS) crosstalk-avoidance codewords. It converts an N-bit codeword into its binary value by serially accumulating Fibonacci weights, one codeword bit per clock. It sits on the receive side of a CAC bus link, between the bus-capture register and the binary datapath. Valid/ready handshakes on both sides allow it to be stalled by either neighbour.

## Interface
Parameters:
- N, default 29: codeword width in bits; legal range 3..40.
- VW, default 21: output value width in bits; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a codeword is presented on cw.
- in_ready  out  1  the block accepts a codeword this cycle.
- cw  in  N  codeword; bit i carries weight F(i).
- out_valid  out  1  v and err are valid.
- out_ready  in  1  the downstream block consumes the result this cycle.
- v  out  VW  decoded binary value.
- err  out  1  forbidden-pattern flag; see Configuration.

## Operation
- Weights: F(0)=1, F(1)=1, F(i)=F(i-1)+F(i-2). Result v = Σ cw[i]·F(i) for i=0..N-1, truncated mod 2^VW. Weight registers are also VW wide and wrap mod 2^VW.
- Worked value: for N=29 the all-ones codeword decodes to F(30)-1 = 1346268, which fits in VW=21.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, latch cw into shift register sr, clear acc, set wa=1, wb=1, idx=0, and go to RUN.
  - RUN: in_ready=0. Each cycle: if sr[0]=1 then acc += wa; then wa←wb, wb←wa+wb, sr←sr>>1, idx←idx+1. When idx=N-1 is processed, register the final acc into v, set out_valid=1, and go to DONE.
  - DONE: out_valid=1, and v and err are held stable. When out_ready=1, clear out_valid and go to IDLE.
- in_valid is ignored outside IDLE. cw changes after acceptance have no effect.
- out_valid never drops without a handshake.
- Reset values: state=IDLE, in_ready=1 once reset releases, out_valid=0, v=0, err=0. All internal registers are 0.
- Reset asserted mid-RUN or in DONE aborts the word immediately; no partial result is ever presented.
- Area: one VW-bit adder for the accumulator, one VW-bit adder for the weights, and a ceil(log2 N)-bit counter.

## Timing
- cw is accepted at edge k (in_valid & in_ready).
- Bits 0..N-1 are processed at edges k+1..k+N. out_valid rises after edge k+N.
- Latency from acceptance to out_valid is N cycles (29 at the default).
- Minimum initiation interval is N+2 cycles: the N RUN cycles, one DONE cycle with out_ready=1, and one IDLE acceptance cycle.
- A stall on out_ready extends DONE indefinitely, with in_ready held at 0.
- No combinational path from any input to any output: in_ready is decoded from state only, and v, err and out_valid are registered.

## Configuration
- Macro: IFNS_FTF_CHECK_EN.
- Defined:
  - During RUN the block keeps the previous two processed bits.
  - Starting at bit index 2, a sticky error bit sets when the triple (bit i-2, i-1, i) equals 101 or 010. These are the forbidden transition patterns of FTF codewords.
  - The sticky bit is cleared on acceptance and registered into err together with v.
  - v is still computed normally when err=1.
- Undefined: err is tied to 0, no check logic is synthesised, and all other behaviour is identical.

## Test plan
- Reset then single words (N=29, VW=21), out_ready=1:
  - cw=0 → v=0.
  - cw=1 → v=1.
  - cw=29'h3 → v=2.
  - cw=29'h1FFFFFFF → v=1346268.
  - In every case out_valid rises exactly 29 cycles after acceptance.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → v and out_valid stay stable and in_ready=0. Release → handshake, then a second word is accepted at the earliest 2 cycles later.
- in_valid toggling during RUN with a different cw → ignored; the result matches the first word only.
- Reset mid-RUN: assert rst_n=0 at cycle 15 of a word → out_valid=0, v=0 and in_ready=1 after release. The next word decodes correctly.
- With IFNS_FTF_CHECK_EN defined:
  - cw=29'h5 → v=3, err=1.
  - cw=29'h2 → v=1, err=1.
  - cw=29'h3 → v=2, err=0.
  - cw=29'h1FFFFFFF → err=0.
- Without IFNS_FTF_CHECK_EN: cw=29'h5 → v=3, err=0.
- Truncation with N=29, VW=20: cw=29'h1FFFFFFF → v=1346268 mod 2^20 = 297692.
